// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and the fetch FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_W    = 26;

  typedef enum logic {FETCH, ISSUE} fetch_state_t;

  function automatic logic is_cond_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC for the instruction held in the issue registers (beq/bne/j, else pc+4).
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        sig_branch,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [15:0] imm;

  always_comb begin
    pc4     = pc + 32'd4;
    imm     = instr[IMM_LSB +: 16];
    next_pc = pc4;
    if (is_cond_branch(instr[OPC_LSB +: 6])) begin
      if (sig_branch) next_pc = pc4 + {{14{imm[15]}}, imm, 2'b00};
    end else if (instr[OPC_LSB +: 6] == OP_J) begin
      next_pc = {pc4[31:28], instr[JIDX_W-1:0], 2'b00};
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// PC owner, instruction fetch over req/ack, and field issue under valid/ready.
// Optional macro BRANCH_DELAY_SLOT_EN enables a one-instruction branch delay slot.
module instr_fetch_issue
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  alu_control,
  output logic [4:0]  shamt,
  output logic [15:0] immediate,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  input  logic        sig_branch,
  output logic [31:0] pc
);

  fetch_state_t state_q;
  logic         req_q, valid_q;
  logic [31:0]  instr_q, pc_q, next_pc_d;

  next_pc_calc u_npc (
    .pc         (pc_q),
    .instr      (instr_q),
    .sig_branch (sig_branch),
    .next_pc    (next_pc_d)
  );

`ifdef BRANCH_DELAY_SLOT_EN
  logic [31:0] delay_target_q;
  logic        slot_pending_q;
  logic        redirect;
  assign redirect = (is_cond_branch(instr_q[OPC_LSB +: 6]) && sig_branch) ||
                    (instr_q[OPC_LSB +: 6] == OP_J);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
      delay_target_q <= '0;
      slot_pending_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            // The slot instruction always falls through to the saved target, even if it branches itself.
            if (slot_pending_q) begin
              pc_q           <= delay_target_q;
              slot_pending_q <= 1'b0;
            end else if (redirect) begin
              pc_q           <= pc_q + 32'd4;
              delay_target_q <= next_pc_d;
              slot_pending_q <= 1'b1;
            end else begin
              pc_q <= next_pc_d;
            end
`else
            pc_q <= next_pc_d;
`endif
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign issue_valid = valid_q;
  assign opcode      = instr_q[OPC_LSB +: 6];
  assign rs_addr     = instr_q[RS_LSB +: 5];
  assign rt_addr     = instr_q[RT_LSB +: 5];
  assign rd_addr     = instr_q[RD_LSB +: 5];
  assign shamt       = instr_q[SHAMT_LSB +: 5];
  assign alu_control = instr_q[FUNCT_LSB +: 6];
  assign immediate   = instr_q[IMM_LSB +: 16];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Table-driven bench for instr_fetch_issue with an issue scoreboard; honours BRANCH_DELAY_SLOT_EN.
module tb_instr_fetch_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, issue_valid, issue_ready, sig_branch;
  logic [31:0] imem_addr, imem_rdata, pc;
  logic [5:0]  opcode, alu_control;
  logic [4:0]  shamt, rs_addr, rt_addr, rd_addr;
  logic [15:0] immediate;

  logic        h_req, h_ack, h_valid, h_ready, h_sb;
  logic [31:0] h_addr, h_rdata, h_pc;
  logic [5:0]  h_op, h_fn;
  logic [4:0]  h_sh, h_rs, h_rt, h_rd;
  logic [15:0] h_imm;

  always #5 clk = ~clk;

  instr_fetch_issue #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .opcode(opcode), .alu_control(alu_control),
    .shamt(shamt), .immediate(immediate), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .sig_branch(sig_branch), .pc(pc)
  );

  instr_fetch_issue #(.RESET_PC(32'h8000_0010)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .imem_req(h_req), .imem_addr(h_addr),
    .imem_ack(h_ack), .imem_rdata(h_rdata), .issue_valid(h_valid),
    .issue_ready(h_ready), .opcode(h_op), .alu_control(h_fn),
    .shamt(h_sh), .immediate(h_imm), .rs_addr(h_rs), .rt_addr(h_rt),
    .rd_addr(h_rd), .sig_branch(h_sb), .pc(h_pc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        sb;
    int          waits;
    int          rdly;
    logic        early;
    logic [31:0] nxt;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[$];
  logic [31:0] sb_q[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] i, input logic s,
                              input int w, input int r, input logic e, input logic [31:0] n);
    vec_t v;
    v.addr = a; v.instr = i; v.sb = s; v.waits = w; v.rdly = r; v.early = e; v.nxt = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    logic ok;
    logic [31:0] want;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
    if (imem_req !== 1'b1) return;
    chk("fetch_addr", imem_addr, v.addr);
    chk("pc_fetch", pc, v.addr);
    ok = 1'b1;
    repeat (v.waits) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== v.addr) ok = 1'b0;
    end
    chk("req_hold", {31'd0, ok}, 32'd1);
    imem_ack = 1'b1; imem_rdata = v.instr; sig_branch = v.sb;
    sb_q.push_back(v.instr);
    if (v.early) issue_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    if (issue_valid === 1'b1 && sb_q.size() > 0) begin
      want = sb_q.pop_front();
      chk("fields", {opcode, rs_addr, rt_addr, rd_addr, shamt, alu_control}, want);
      chk("imm", {16'd0, immediate}, {16'd0, want[15:0]});
    end
    if (!v.early) begin
      ok = 1'b1;
      repeat (v.rdly) begin
        sig_branch = ~v.sb;
        @(negedge clk);
        if (issue_valid !== 1'b1 || pc !== v.addr ||
            {opcode, rs_addr, rt_addr, rd_addr, shamt, alu_control} !== v.instr) ok = 1'b0;
      end
      if (v.rdly > 0) chk("stall_hold", {31'd0, ok}, 32'd1);
      sig_branch = v.sb;
      issue_ready = 1'b1;
    end
    @(negedge clk);
    issue_ready = 1'b0; sig_branch = ~v.sb;
    chk("valid_clear", {31'd0, issue_valid}, 32'd0);
    chk("next_pc", pc, v.nxt);
    chk("req_gap", {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; issue_ready = 1'b0; sig_branch = 1'b0;
    h_ack = 1'b0; h_rdata = '0; h_ready = 1'b0; h_sb = 1'b0;

`ifdef BRANCH_DELAY_SLOT_EN
    tbl.push_back(mk(32'h100, 32'h0800_0010, 1'b0, 0, 0, 1'b0, 32'h104));
    tbl.push_back(mk(32'h104, 32'h012A_4020, 1'b0, 1, 0, 1'b0, 32'h040));
    tbl.push_back(mk(32'h040, 32'h1422_0004, 1'b1, 0, 0, 1'b0, 32'h044));
    tbl.push_back(mk(32'h044, 32'h012A_4020, 1'b0, 0, 0, 1'b1, 32'h054));
    tbl.push_back(mk(32'h054, 32'h1422_0010, 1'b1, 2, 0, 1'b0, 32'h058));
    tbl.push_back(mk(32'h058, 32'h0800_0000, 1'b1, 0, 0, 1'b0, 32'h098));
    tbl.push_back(mk(32'h098, 32'h0009_40C0, 1'b0, 0, 5, 1'b0, 32'h09C));
`else
    tbl.push_back(mk(32'h100,       32'h012A_4020, 1'b0, 2, 0, 1'b0, 32'h104));
    tbl.push_back(mk(32'h104,       32'h1022_FFBD, 1'b1, 0, 0, 1'b0, 32'hFFFF_FFFC));
    tbl.push_back(mk(32'hFFFF_FFFC, 32'h012A_4020, 1'b0, 1, 0, 1'b0, 32'h000));
    tbl.push_back(mk(32'h000,       32'h1022_007F, 1'b1, 0, 0, 1'b0, 32'h200));
    tbl.push_back(mk(32'h200,       32'h1022_FFFE, 1'b1, 1, 0, 1'b0, 32'h1FC));
    tbl.push_back(mk(32'h1FC,       32'h012A_4020, 1'b1, 0, 0, 1'b1, 32'h200));
    tbl.push_back(mk(32'h200,       32'h1022_FFFE, 1'b0, 0, 0, 1'b0, 32'h204));
    tbl.push_back(mk(32'h204,       32'h1422_0010, 1'b0, 0, 0, 1'b0, 32'h208));
    tbl.push_back(mk(32'h208,       32'h1422_0010, 1'b1, 3, 0, 1'b0, 32'h24C));
    tbl.push_back(mk(32'h24C,       32'h0800_0100, 1'b1, 0, 0, 1'b0, 32'h400));
    tbl.push_back(mk(32'h400,       32'h0009_40C0, 1'b0, 0, 5, 1'b0, 32'h404));
`endif

    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_fields", {opcode, rs_addr, rt_addr, rd_addr, shamt, alu_control}, 32'd0);
    chk("rst_imm", {16'd0, immediate}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc_hi", h_pc, 32'h8000_0010);
    rst_n = 1'b1;

    // j at a high address keeps pc4[31:28]
    n = 0;
    while (h_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("hi_req", {31'd0, h_req}, 32'd1);
    chk("hi_addr", h_addr, 32'h8000_0010);
    h_ack = 1'b1; h_rdata = 32'h0800_0040;
    @(negedge clk);
    h_ack = 1'b0;
    chk("hi_valid", {31'd0, h_valid}, 32'd1);
    h_ready = 1'b1; h_sb = 1'b1;
    @(negedge clk);
    h_ready = 1'b0;
    @(negedge clk);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("hi_jaddr", h_addr, 32'h8000_0014);
`else
    chk("hi_jaddr", h_addr, 32'h8000_0100);
`endif
    chk("hi_req2", {31'd0, h_req}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
      if (i == 0) begin
        chk("add_rs", {27'd0, rs_addr}, 32'd9);
        chk("add_rt", {27'd0, rt_addr}, 32'd10);
        chk("add_rd", {27'd0, rd_addr}, 32'd8);
        chk("add_funct", {26'd0, alu_control}, 32'h20);
      end
    end

    // Reset while waiting for ack; an ack on the reset edge and one while req is low are both dropped
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1422_0010;
    @(negedge clk);
    chk("wrst_req", {31'd0, imem_req}, 32'd0);
    chk("wrst_pc", pc, 32'h100);
    chk("wrst_valid", {31'd0, issue_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, issue_valid}, 32'd0);
    chk("late_ack_op", {26'd0, opcode}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    run_vec(mk(32'h100, 32'h012A_4020, 1'b0, 0, 0, 1'b0, 32'h104));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
# instr_fetch_issue

Sequential front end that feeds the 32-bit MIPS-style ALU datapath. It owns the program counter and fetches instruction words over a req/ack instruction-memory port. It splits each word into opcode, funct, shamt, immediate and register addresses, and presents them to the ALU/register-file stage under a valid/ready handshake. It consumes the ALU's `sig_branch` result to choose the next PC for beq/bne, and also resolves j.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  single-cycle acknowledge; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `issue_valid`  out  1  decoded fields valid.
- `issue_ready`  in  1  downstream accepts the fields.
- `opcode`  out  6  instr[31:26].
- `alu_control`  out  6  instr[5:0] (funct).
- `shamt`  out  5  instr[10:6].
- `immediate`  out  16  instr[15:0].
- `rs_addr`, `rt_addr`, `rd_addr`  out  5 each  instr[25:21], [20:16], [15:11].
- `sig_branch`  in  1  ALU branch decision; sampled only on an accepted beq/bne.
- `pc`  out  32  address of the instruction currently fetched or issued.

## Operation
- States are FETCH and ISSUE; the reset state is FETCH.
- Reset values:
  - `imem_req`=0.
  - `issue_valid`=0.
  - All field outputs are 0.
  - `pc`=`RESET_PC`.
  - Internal `slot_pending`=0.
- FETCH:
  - `imem_req` is a registered output. It rises on the first edge in FETCH while low.
  - Once high, `imem_req` and `imem_addr` hold stable until an edge where `imem_req`=1 and `imem_ack`=1.
  - On that edge, capture `imem_rdata` into the field registers, drop `imem_req`, set `issue_valid`, and go to ISSUE.
  - `imem_ack` while `imem_req`=0 is ignored.
- ISSUE:
  - Fields and `issue_valid` hold until an edge with `issue_ready`=1 (the accept edge).
  - On the accept edge, clear `issue_valid`, load `pc` with next_pc, and return to FETCH.
- next_pc, with pc4 = pc+4 (all arithmetic modulo 2^32):
  - opcode 6'h04/6'h05 with `sig_branch`=1: pc4 + ({{14{imm[15]}},imm,2'b00}).
  - opcode 6'h04/6'h05 with `sig_branch`=0: pc4.
  - opcode 6'h02 (j): {pc4[31:28], instr[25:0], 2'b00}.
  - All other opcodes, including R-type: pc4.
- `sig_branch` is ignored for all non-branch opcodes.
- PC wrap from 32'hFFFF_FFFC to 32'h0 is silent.

## Timing
- Ack at edge n: `issue_valid`=1 from cycle n+1.
- Accept at edge m: `imem_req`=1 from cycle m+2 (one cycle in FETCH with `req` low). Throughput is one instruction per 3 cycles at best.
- `issue_ready` held high when `issue_valid` rises: accept happens on the first edge of ISSUE.
- `rst_n` low at any edge, in any state, overrides all other activity. The next cycle shows reset values, and any outstanding ack is discarded.
- An ack arriving on the same edge as reset is lost.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined:
  - An accepted taken branch or j loads `pc` with pc4 and stores the target in a `delay_target` register, setting `slot_pending`=1.
  - The next accepted instruction (the slot) loads `pc` from `delay_target` and clears `slot_pending`.
  - A branch or jump in the slot is executed as a non-branch: next_pc is `delay_target`.
- `BRANCH_DELAY_SLOT_EN` undefined:
  - No delay slot; a taken branch or j redirects immediately.
  - `delay_target` and `slot_pending` are not present.

## Structure
- `mips_pkg`, shared with the ALU/control code, holds:
  - Opcode constants: OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_BNE=6'h05.
  - Field-position localparams.
  - The `fetch_state_t` enum {FETCH, ISSUE}.
- One sub-module, `next_pc_calc`: combinational. Inputs are pc, instr, and sig_branch; the output is next_pc.

## Test plan
- Reset with RESET_PC=32'h100 and ack after 2 wait cycles, rdata=32'h012A4020 (add) -> `imem_addr`=32'h100; fields rs=9, rt=10, rd=8, funct=6'h20; next fetch at 32'h104.
- beq at 32'h200 with imm=16'hFFFE, `sig_branch`=1 -> next `imem_addr`=32'h1FC. With `sig_branch`=0 -> 32'h204.
- j at 32'h8000_0010 with instr[25:0]=26'h40 -> next `imem_addr`=32'h8000_0100.
- `issue_ready` low for 5 cycles -> fields and `issue_valid` stable throughout; exactly one PC update after ready rises.
- `rst_n` pulled low in WAIT (req high, no ack) -> `imem_req`=0 and `pc`=RESET_PC next cycle; a late ack is ignored.
- With `BRANCH_DELAY_SLOT_EN`: taken bne at 32'h40, imm=16'h0004 -> fetches 32'h44 (slot), then 32'h54.
